// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry skid pipeline stage: FSM state and default widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   localparam int PAYLOAD_W_DEF   = 69;
   localparam int CTRL_W_DEF      = 2;
   localparam int STALL_CNT_W_DEF = 16;

   function automatic logic [1:0] occ_of(input pipe_state_e st);
      case (st)
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by the active-low reset.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) valid/ready pipeline stage with registered handshake outputs,
// synchronous flush and a saturating backpressure counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W   = PAYLOAD_W_DEF,
   parameter int CTRL_W      = CTRL_W_DEF,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PAYLOAD_W-1:0]   in_payload,
   input  logic [CTRL_W-1:0]      in_ctrl,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PAYLOAD_W-1:0]   out_payload,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_count
);

   pipe_state_e          state_q, state_d;
   logic [PAYLOAD_W-1:0] main_pay_q, main_pay_d;
   logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d;
   logic [PAYLOAD_W-1:0] skid_pay_q, skid_pay_d;
   logic [CTRL_W-1:0]    skid_ctrl_q, skid_ctrl_d;
   logic                 out_valid_q;
   logic                 in_ready_q;
   logic [1:0]           occ_q;
   logic                 in_fire;
   logic                 out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      main_pay_d  = main_pay_q;
      main_ctrl_d = main_ctrl_q;
      skid_pay_d  = skid_pay_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         // Flush wins: any entry arriving this cycle is dropped with the rest.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_pay_d  = in_payload;
                  main_ctrl_d = in_ctrl;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_pay_d  = in_payload;
                  main_ctrl_d = in_ctrl;
               end else if (in_fire) begin
                  skid_pay_d  = in_payload;
                  skid_ctrl_d = in_ctrl;
                  state_d     = TWO;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_pay_d  = skid_pay_q;
                  main_ctrl_d = skid_ctrl_q;
                  state_d     = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Handshake outputs are registered from the next state so no input reaches them combinationally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         main_pay_q  <= '0;
         main_ctrl_q <= '0;
         skid_pay_q  <= '0;
         skid_ctrl_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_pay_q  <= main_pay_d;
         main_ctrl_q <= main_ctrl_d;
         skid_pay_q  <= skid_pay_d;
         skid_ctrl_q <= skid_ctrl_d;
         out_valid_q <= (state_d != EMPTY);
         in_ready_q  <= (state_d != TWO);
         occ_q       <= occ_of(state_d);
      end
   end

   assign out_valid   = out_valid_q;
   assign in_ready    = in_ready_q;
   assign occupancy   = occ_q;
   assign out_payload = main_pay_q;
   assign out_ctrl    = out_valid_q ? main_ctrl_q : '0;

   sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (out_valid_q & ~out_ready),
      .count (stall_count)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a two-deep queue model.
module tb_pipe_stage_skid;

   localparam int PW = 69;
   localparam int CW = 2;

   typedef struct {
      logic [PW-1:0] p;
      logic [CW-1:0] c;
   } ent_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          out_ready;
   logic [PW-1:0] in_payload;
   logic [CW-1:0] in_ctrl;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] out_payload;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [15:0]   stall_count;

   logic          in_valid4;
   logic          out_ready4;
   logic [PW-1:0] in_payload4;
   logic [CW-1:0] in_ctrl4;
   logic          in_ready4;
   logic          out_valid4;
   logic [PW-1:0] out_payload4;
   logic [CW-1:0] out_ctrl4;
   logic [1:0]    occupancy4;
   logic [3:0]    stall_count4;

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t mq[$];
   int   m_stall;
   int   n_deliv;
   int   n_flush;

   always #5 clock = ~clock;

   pipe_stage_skid dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (in_payload),
      .in_ctrl     (in_ctrl),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload),
      .out_ctrl    (out_ctrl),
      .occupancy   (occupancy),
      .stall_count (stall_count)
   );

   pipe_stage_skid #(.STALL_CNT_W(4)) dut4 (
      .clock       (clock),
      .reset       (reset),
      .flush       (1'b0),
      .in_valid    (in_valid4),
      .in_ready    (in_ready4),
      .in_payload  (in_payload4),
      .in_ctrl     (in_ctrl4),
      .out_valid   (out_valid4),
      .out_ready   (out_ready4),
      .out_payload (out_payload4),
      .out_ctrl    (out_ctrl4),
      .occupancy   (occupancy4),
      .stall_count (stall_count4)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() < 2);
      chk("occupancy", occupancy, mq.size());
      chk("stall_count", stall_count, m_stall);
      if (mq.size() != 0) begin
         chk("out_payload", out_payload, mq[0].p);
         chk("out_ctrl", out_ctrl, mq[0].c);
      end else begin
         chk("out_ctrl_bubble", out_ctrl, '0);
      end
   endtask

   // One clock: check the DUT against the model, then advance the model by the queue rules.
   task automatic cycle();
      bit   ifire;
      bit   ofire;
      ent_t e;
      compare_outputs();
      ifire = in_valid && (mq.size() < 2);
      ofire = out_ready && (mq.size() != 0);
      if ((mq.size() != 0) && !out_ready && (m_stall < 16'hFFFF)) m_stall++;
      if (flush) begin
         mq.delete();
         n_flush++;
      end else begin
         if (ofire) begin
            void'(mq.pop_front());
            n_deliv++;
         end
         if (ifire) begin
            e.p = in_payload;
            e.c = in_ctrl;
            mq.push_back(e);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      flush      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_payload = '0;
      in_ctrl    = '0;
      in_valid4  = 1'b0;
      out_ready4 = 1'b0;
      in_payload4 = '0;
      in_ctrl4   = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      chk({tag, "_occ"}, occupancy, 2'd0);
      chk({tag, "_out_ctrl"}, out_ctrl, '0);
      chk({tag, "_out_payload"}, out_payload, '0);
      chk({tag, "_stall"}, stall_count, 16'd0);
      chk({tag, "_stall4"}, stall_count4, 4'd0);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      repeat (2) @(posedge clock);
      #1;
      check_reset_outputs("rst_hold");
      mq.delete();
      m_stall = 0;
      reset = 1'b1;
      #1;
   endtask

   initial begin
      m_stall = 0;
      n_deliv = 0;
      n_flush = 0;
      idle_inputs();
      reset = 1'b0;
      @(posedge clock);
      #1;

      do_reset();
      $display("reset: out_valid=%0b in_ready=%0b occ=%0d stall=%0d", out_valid, in_ready, occupancy, stall_count);

      // Single entry, 1-cycle latency.
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_payload = {32'd1234, 32'd12345, 5'd31};
      in_ctrl    = 2'b11;
      cycle();
      in_valid = 1'b0;
      chk("lat_valid", out_valid, 1'b1);
      chk("lat_payload", out_payload, {32'd1234, 32'd12345, 5'd31});
      chk("lat_ctrl", out_ctrl, 2'b11);
      chk("lat_occ", occupancy, 2'd1);
      $display("latency: out_valid=%0b payload=%0h ctrl=%0b", out_valid, out_payload, out_ctrl);
      cycle();
      cycle();

      // Backpressure: fill both entries, then drain in order.
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_payload = 69'd5; in_ctrl = 2'b01;
      cycle();
      in_payload = 69'd6; in_ctrl = 2'b10;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("bp_occ", occupancy, 2'd2);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_stall", stall_count, 16'd2);
      out_ready = 1'b1;
      chk("bp_head_a", out_payload, 69'd5);
      cycle();
      chk("bp_head_b", out_payload, 69'd6);
      chk("bp_ready_back", in_ready, 1'b1);
      cycle();
      chk("bp_drained", out_valid, 1'b0);
      $display("backpressure: drained A,B stall=%0d", stall_count);
      cycle();

      // Flush with simultaneous push while full.
      do_reset();
      in_valid = 1'b1; in_payload = 69'd3; cycle();
      in_payload = 69'd4; cycle();
      flush = 1'b1; in_payload = 69'd7; in_ctrl = 2'b11;
      cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("fl_occ", occupancy, 2'd0);
      chk("fl_valid", out_valid, 1'b0);
      chk("fl_ctrl", out_ctrl, 2'b00);
      repeat (3) cycle();
      $display("flush: occ=%0d out_valid=%0b", occupancy, out_valid);

      // Mid-operation reset while full, then accept on first edge after release.
      in_valid = 1'b1; out_ready = 1'b0; in_payload = 69'h1_2345_6789; in_ctrl = 2'b11;
      cycle();
      in_payload = 69'h0_0000_00AA; cycle();
      chk("pre_rst_occ", occupancy, 2'd2);
      do_reset();
      in_valid = 1'b1; in_payload = 69'h0_0000_0BEE; in_ctrl = 2'b10;
      cycle();
      in_valid = 1'b0;
      chk("post_rst_accept", out_payload, 69'h0_0000_0BEE);
      $display("midop reset: accepted payload=%0h after release", out_payload);

      // 4-bit stall counter saturation on the narrow instance.
      do_reset();
      in_valid4 = 1'b1; in_payload4 = 69'h155; in_ctrl4 = 2'b01;
      cycle();
      in_valid4 = 1'b0;
      repeat (20) cycle();
      chk("sat_stall15", stall_count4, 4'd15);
      chk("sat_occ", occupancy4, 2'd1);
      chk("sat_valid", out_valid4, 1'b1);
      chk("sat_in_ready", in_ready4, 1'b1);
      chk("sat_payload", out_payload4, 69'h155);
      chk("sat_ctrl", out_ctrl4, 2'b01);
      repeat (3) cycle();
      chk("sat_hold15", stall_count4, 4'd15);
      $display("saturation: stall_count4=%0d", stall_count4);

      // Random traffic against the queue model.
      do_reset();
      n_deliv = 0;
      n_flush = 0;
      for (int i = 0; i < 10000; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 63) == 0);
         in_payload = {$urandom, $urandom, $urandom};
         in_ctrl    = CW'($urandom);
         cycle();
      end
      idle_inputs();
      out_ready = 1'b1;
      repeat (3) cycle();
      $display("random: delivered=%0d flushes=%0d", n_deliv, n_flush);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 69: data payload width (read data 32 + ALU result 32 + rd 5).
REQ-002 SHALL have parameter CTRL_W, default 2: control-field width (reg_write, mem_to_reg).
REQ-003 SHALL have parameter STALL_CNT_W, default 16: stall-counter width.
REQ-004 SHALL have ports: clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have ports: flush  in  1  synchronous pipeline flush.
REQ-007 SHALL have ports: in_valid  in  1  upstream entry valid.
REQ-008 SHALL have ports: in_ready  out  1  stage can accept; driven directly from a register.
REQ-009 SHALL have ports: in_payload  in  PAYLOAD_W  upstream data.
REQ-010 SHALL have ports: in_ctrl  in  CTRL_W  upstream control field.
REQ-011 SHALL have ports: out_valid  out  1  downstream entry valid.
REQ-012 SHALL have ports: out_ready  in  1  downstream accepts.
REQ-013 SHALL have ports: out_payload  out  PAYLOAD_W  head-entry data.
REQ-014 SHALL have ports: out_ctrl  out  CTRL_W  head-entry control, 0 whenever out_valid=0.
REQ-015 SHALL have ports: occupancy  out  2  entries held (0..2).
REQ-016 SHALL have ports: stall_count  out  STALL_CNT_W  saturating count of backpressured cycles.

Function
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 SHALL hold two entries, main (head) and skid, under FSM states EMPTY, ONE, TWO.
REQ-019 SHALL decode outputs from state: out_valid = (state != EMPTY); in_ready = (state != TWO); occupancy = 0/1/2.
REQ-020 SHALL, in EMPTY, load main and go to ONE on in_fire; otherwise stay in EMPTY.
REQ-021 SHALL, in ONE, behave as follows: in_fire & out_fire -> main <= input, stay ONE; in_fire only -> skid <= input, go TWO; out_fire only -> go EMPTY; neither -> hold.
REQ-022 SHALL, in TWO, move main <= skid and go to ONE on out_fire; otherwise hold.
REQ-023 SHALL give a latency of exactly 1 cycle from in_fire into EMPTY to out_valid=1 carrying that entry.
REQ-024 SHALL have no combinational path from in_* to out_* or from out_ready to in_ready.
REQ-025 SHALL deliver entries in strict FIFO order, with no loss or duplication.
REQ-026 SHALL take flush=1 over all other events: the next state is EMPTY, and any same-cycle in_fire is discarded (neither entry is counted as delivered).
REQ-027 SHALL gate out_ctrl with out_valid so that a bubble never asserts reg_write.
REQ-028 SHALL increment stall_count on each cycle with out_valid=1 and out_ready=0, and saturate it at all-ones.
REQ-029 SHALL not clear stall_count on flush; only reset clears it.
REQ-030 SHALL leave out_payload at its last value when going to EMPTY, so consumers use it only when out_valid=1.

Reset
REQ-031 SHALL, while reset=0, immediately force: state=EMPTY, main=0, skid=0, stall_count=0, giving out_valid=0, in_ready=1, occupancy=0, out_payload=0, out_ctrl=0.
REQ-032 SHALL, on reset asserted mid-operation with occupancy 2, discard both entries with no partial outputs.
REQ-033 SHALL accept in_fire on the first rising edge after reset deasserts.

Structure
REQ-034 SHALL place the FSM state enum (EMPTY, ONE, TWO) and default widths (PAYLOAD_W=69, CTRL_W=2, STALL_CNT_W=16) in shared package pipe_pkg.
REQ-035 SHALL implement the saturating counter as sub-module sat_counter (parameter WIDTH; ports clock, reset, inc, count).
REQ-036 SHALL keep datapath registers free of reset-dependent logic beyond the required zeroing.

Verification
REQ-037 SHALL cover: reset=0 for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, stall_count=0.
REQ-038 SHALL cover: out_ready=1, in_valid=1 with payload {1234, 12345, 31}, ctrl=2'b11 -> next cycle out_valid=1, same payload, out_ctrl=2'b11, occupancy=1.
REQ-039 SHALL cover: out_ready=0, push A=5 then B=6 -> occupancy=2, in_ready=0, stall_count=2 after 2 stalled cycles; then out_ready=1 -> A then B on consecutive cycles, in_ready returns to 1.
REQ-040 SHALL cover: occupancy=2 with flush=1 and in_valid=1 (C=7) in the same cycle -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and C is never output.
REQ-041 SHALL cover: STALL_CNT_W=4, out_ready=0 for 20 cycles with one entry -> stall_count=15 and holds at 15.
REQ-042 SHALL cover: random valid/ready for 10,000 cycles against a scoreboard queue -> order preserved, no loss or duplication, no out_ctrl!=0 while out_valid=0.
